pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline (pc_reg, if_id, id_ex, ex_mem, mem_wb).

---
 rtl/pipeline_ctrl_pkg.sv | 25 ++
 rtl/pipeline_ctrl_stall_prio_enc.sv | 27 ++
 rtl/pipeline_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Stage bit indices, canned stall vectors and controller FSM states.
package pipeline_ctrl_pkg;

  localparam int StallBus = 6;

  localparam int StallPC  = 0;
  localparam int StallIF  = 1;
  localparam int StallID  = 2;
  localparam int StallEX  = 3;
  localparam int StallMEM = 4;
  localparam int StallWB  = 5;

  localparam logic [StallBus-1:0] StallVecMem  = 6'b011111;
  localparam logic [StallBus-1:0] StallVecEx   = 6'b001111;
  localparam logic [StallBus-1:0] StallVecId   = 6'b000111;
  localparam logic [StallBus-1:0] StallVecIf   = 6'b000011;
  localparam logic [StallBus-1:0] StallVecNone = 6'b000000;

  typedef enum logic {
    CtrlRun  = 1'b0,
    CtrlHold = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_stall_prio_enc.sv
// Priority encoder: four stall requests -> freeze vector.
// The deepest requesting stage wins; WB is never frozen.
module stall_prio_enc
  import pipeline_ctrl_pkg::*;
(
  input  logic                req_if_i,
  input  logic                req_id_i,
  input  logic                req_ex_i,
  input  logic                req_mem_i,
  output logic [StallBus-1:0] stall_o
);

  // Deepest stage first: freezing it must also freeze everything upstream.
  always_comb begin
    stall_o = StallVecNone;
    if (req_mem_i) begin
      stall_o = StallVecMem;
    end else if (req_ex_i) begin
      stall_o = StallVecEx;
    end else if (req_id_i) begin
      stall_o = StallVecId;
    end else if (req_if_i) begin
      stall_o = StallVecIf;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Optional stall watchdog: define PIPE_CTRL_WDT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 32,
  parameter int WDT_LIMIT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                branch_flag,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic [StallBus-1:0] stall,
  output logic                flush_if_id,
  output logic                flush_id_ex,
  output logic                redirect_valid,
  output logic [ADDR_W-1:0]   redirect_pc,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic                stall_timeout
);

  logic [StallBus-1:0] stall_raw;
  ctrl_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   held_q, held_d;
  logic [CNT_W-1:0]    stall_cycles_q;
  logic                fif, fie, rv;
  logic [ADDR_W-1:0]   rpc;
  logic                accept;

  stall_prio_enc u_enc (
    .req_if_i  (stallreq_if),
    .req_id_i  (stallreq_id),
    .req_ex_i  (stallreq_ex),
    .req_mem_i (stallreq_mem),
    .stall_o   (stall_raw)
  );

  // A branch only counts when EX is advancing; otherwise EX re-presents it.
  assign accept = branch_flag && !stall_raw[StallEX];

  // Redirect FSM: redirect now, or park the target until PC is free.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    fif     = 1'b0;
    fie     = 1'b0;
    rv      = 1'b0;
    rpc     = branch_target;
    unique case (state_q)
      CtrlRun: begin
        if (accept) begin
          fif = 1'b1;
          fie = 1'b1;
          if (!stall_raw[StallPC]) begin
            rv = 1'b1;
          end else begin
            held_d  = branch_target;
            state_d = CtrlHold;
          end
        end
      end
      CtrlHold: begin
        fif = 1'b1;
        rpc = held_q;
        if (!stall_raw[StallPC]) begin
          rv      = 1'b1;
          state_d = CtrlRun;
        end
      end
      default: state_d = CtrlRun;
    endcase
  end

  // FSM state and parked redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CtrlRun;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  // Saturating count of cycles in which the PC was frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (stall_raw[StallPC] && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

`ifdef PIPE_CTRL_WDT_EN
  localparam int WdtW = $clog2(WDT_LIMIT + 1) + 1;

  logic [WdtW-1:0] wdt_q;
  logic            timeout_q;

  // Run length of the current stall; sticky flag once it hits the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (!stall_raw[StallPC]) begin
      wdt_q <= '0;
    end else begin
      if (wdt_q < WdtW'(WDT_LIMIT)) begin
        wdt_q <= wdt_q + 1'b1;
      end
      if (wdt_q + 1'b1 >= WdtW'(WDT_LIMIT)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign stall_timeout = timeout_q && !rst;
`else
  logic unused_wdt;
  assign unused_wdt    = ^WDT_LIMIT;
  assign stall_timeout = 1'b0;
`endif

  assign stall          = rst ? '0 : stall_raw;
  assign flush_if_id    = fif && !rst;
  assign flush_id_ex    = fie && !rst;
  assign redirect_valid = rv && !rst;
  assign redirect_pc    = rst ? '0 : rpc;
  assign stall_cycles   = rst ? '0 : stall_cycles_q;

  // A branch resolving while a redirect is parked would be lost.
  a_no_branch_in_hold : assert property (
    @(posedge clk) disable iff (rst)
      !(state_q == CtrlHold && branch_flag)
  ) else $error("branch_flag asserted while redirect pending");

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl.
// Driver queues hand-computed expectations; monitor checks each cycle.
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_WDT_EN
  localparam bit WdtOn = 1'b1;
`else
  localparam bit WdtOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_if = 1'b0, s_id = 1'b0;
  logic        s_ex = 1'b0, s_mem = 1'b0;
  logic        bf = 1'b0;
  logic [31:0] tgt = '0;
  logic [5:0]  stall;
  logic        fif, fie, rv;
  logic [31:0] rpc;
  logic [2:0]  cyc;
  logic        tmo;

  typedef struct {
    logic [5:0]  stall;
    logic        fif;
    logic        fie;
    logic        rv;
    logic [31:0] rpc;
    logic [2:0]  cyc;
    logic        tmo;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   row = 0;

  pipeline_ctrl #(
    .ADDR_W   (32),
    .CNT_W    (3),
    .WDT_LIMIT(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (s_if),
    .stallreq_id   (s_id),
    .stallreq_ex   (s_ex),
    .stallreq_mem  (s_mem),
    .branch_flag   (bf),
    .branch_target (tgt),
    .stall         (stall),
    .flush_if_id   (fif),
    .flush_id_ex   (fie),
    .redirect_valid(rv),
    .redirect_pc   (rpc),
    .stall_cycles  (cyc),
    .stall_timeout (tmo)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int r,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h",
               nm, r, act, exp);
    end
  endfunction

  task automatic step(
    input logic r, i_if, i_id, i_ex, i_mem,
    input logic b, input logic [31:0] t,
    input logic [5:0] e_st,
    input logic e_fif, e_fie, e_rv,
    input logic [31:0] e_rpc,
    input int e_cyc, input logic e_to
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst   = r;
    s_if  = i_if;
    s_id  = i_id;
    s_ex  = i_ex;
    s_mem = i_mem;
    bf    = b;
    tgt   = t;
    e.stall = e_st;
    e.fif   = e_fif;
    e.fie   = e_fie;
    e.rv    = e_rv;
    e.rpc   = e_rpc;
    e.cyc   = 3'(e_cyc);
    e.tmo   = e_to & WdtOn;
    q.push_back(e);
  endtask

  // Monitor: every cycle presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stall", row, 32'(stall), 32'(e.stall));
        chk("flush_if_id", row, 32'(fif), 32'(e.fif));
        chk("flush_id_ex", row, 32'(fie), 32'(e.fie));
        chk("redirect_valid", row, 32'(rv), 32'(e.rv));
        if (e.rv) chk("redirect_pc", row, rpc, e.rpc);
        chk("stall_cycles", row, 32'(cyc), 32'(e.cyc));
        chk("stall_timeout", row, 32'(tmo), 32'(e.tmo));
        row++;
      end
    end
  end

  initial begin
    int waited;
    // rst,if,id,ex,mem,bf,tgt | stall,fif,fie,rv,rpc,cyc,to
    step(1,0,0,0,1,0,0,     6'b000000,0,0,0,0,0,0);
    step(0,0,1,0,1,0,0,     6'b011111,0,0,0,0,0,0);
    step(0,0,1,0,0,0,0,     6'b000111,0,0,0,0,1,0);
    step(0,0,0,0,0,0,0,     6'b000000,0,0,0,0,2,0);
    step(0,0,0,0,0,1,'h100, 6'b000000,1,1,1,'h100,2,0);
    step(0,1,0,0,0,1,'h200, 6'b000011,1,1,0,0,2,0);
    step(0,1,0,0,0,0,0,     6'b000011,1,0,0,0,3,0);
    step(0,1,0,0,0,0,0,     6'b000011,1,0,0,0,4,0);
    step(0,0,0,0,0,0,0,     6'b000000,1,0,1,'h200,5,0);
    step(0,0,0,0,0,0,0,     6'b000000,0,0,0,0,5,0);
    step(0,0,0,1,0,0,0,     6'b001111,0,0,0,0,5,0);
    step(1,0,0,0,0,0,0,     6'b000000,0,0,0,0,0,0);
    step(0,0,0,0,1,1,'h300, 6'b011111,0,0,0,0,0,0);
    step(0,0,0,0,1,1,'h300, 6'b011111,0,0,0,0,1,0);
    step(0,0,0,0,0,1,'h300, 6'b000000,1,1,1,'h300,2,0);
    step(0,0,0,0,0,0,0,     6'b000000,0,0,0,0,2,0);
    step(0,1,0,0,0,1,'h400, 6'b000011,1,1,0,0,2,0);
    step(1,0,0,0,0,0,0,     6'b000000,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0,     6'b000000,0,0,0,0,0,0);
    for (int k = 0; k < 9; k++) begin
      step(0,0,0,1,0,0,0, 6'b001111,0,0,0,0,
           (k > 7) ? 7 : k, (k == 8));
    end
    step(0,0,0,0,0,0,0,     6'b000000,0,0,0,0,7,1);
    step(1,0,0,0,0,0,0,     6'b000000,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0,     6'b000000,0,0,0,0,0,0);
    waited = 0;
    while (q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
